// File: rtl/cam_encoder_pkg.sv
// cam_encoder_pkg: resolution codes, geometry defaults, state encoding and RGB565 packing
package cam_encoder_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_VS, ST_VBP, ST_ACT, ST_VFP} state_e;

    localparam int HCNT_W = 12;
    localparam int VCNT_W = 11;

    localparam logic [1:0] P_RESOL_VGA  = 2'b00;
    localparam logic [1:0] P_RESOL_XGA  = 2'b01;
    localparam logic [1:0] P_RESOL_SXGA = 2'b10;

    localparam int VGA_W  = 640;
    localparam int VGA_H  = 480;
    localparam int XGA_W  = 1024;
    localparam int XGA_H  = 768;
    localparam int SXGA_W = 1280;
    localparam int SXGA_H = 1024;

    function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/cam_encoder_if.sv
// cam_encoder_if: FIFO-side handshake and camera-side byte stream of the encoder
interface cam_encoder_if;
    logic        ENABLE;
    logic [1:0]  RESOL;
    logic [47:0] FIFOOUT;
    logic        FIFOEMPTY;
    logic        FIFORD;
    logic        HREF;
    logic        VSYNC;
    logic [7:0]  CAMDATA;
    logic        FRAMEEND;
    logic        UNDERFLOW;

    modport master (
        output ENABLE, RESOL, FIFOOUT, FIFOEMPTY,
        input  FIFORD, HREF, VSYNC, CAMDATA, FRAMEEND, UNDERFLOW
    );

    modport slave (
        input  ENABLE, RESOL, FIFOOUT, FIFOEMPTY,
        output FIFORD, HREF, VSYNC, CAMDATA, FRAMEEND, UNDERFLOW
    );
endinterface

// File: rtl/cam_encoder_timing.sv
// cam_timing_gen: frame state machine with line/pixel counters and raw sync/phase outputs
module cam_timing_gen
    import cam_encoder_pkg::*;
#(
    parameter int P_HBLANK      = 144,
    parameter int P_VSYNC_LINES = 3,
    parameter int P_VBP_LINES   = 17,
    parameter int P_VFP_LINES   = 10,
    parameter int P_VGA_W       = VGA_W,
    parameter int P_VGA_H       = VGA_H,
    parameter int P_XGA_W       = XGA_W,
    parameter int P_XGA_H       = XGA_H,
    parameter int P_SXGA_W      = SXGA_W,
    parameter int P_SXGA_H      = SXGA_H
) (
    input  logic       PCLK,
    input  logic       PRST_N,
    input  logic       enable_i,
    input  logic [1:0] resol_i,
    output logic       href_o,
    output logic       vsync_o,
    output logic       frameend_o,
    output logic [1:0] phase_o
);
    state_e              state_q, state_d, state_nxt;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d, act_len, line_len;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d, lines;
    logic [VCNT_W-1:0]   w_q, w_d, h_q, h_d;
    logic                line_end, state_end;

    assign act_len   = {w_q, 1'b0};
    assign line_len  = act_len + HCNT_W'(P_HBLANK);
    assign lines     = state_q == ST_VS  ? VCNT_W'(P_VSYNC_LINES) :
                       state_q == ST_VBP ? VCNT_W'(P_VBP_LINES) :
                       state_q == ST_ACT ? h_q : VCNT_W'(P_VFP_LINES);
    assign line_end  = hcnt_q == line_len - HCNT_W'(1);
    assign state_end = line_end && vcnt_q == lines - VCNT_W'(1);
    assign state_nxt = state_q == ST_VS  ? ST_VBP :
                       state_q == ST_VBP ? ST_ACT :
                       state_q == ST_ACT ? ST_VFP :
                       enable_i ? ST_VS : ST_IDLE;

    assign href_o     = state_q == ST_ACT && hcnt_q < act_len;
    assign vsync_o    = state_q == ST_VS;
    assign frameend_o = state_q == ST_VFP && state_end;
    assign phase_o    = hcnt_q[1:0];

    // Advance counters and state; geometry is captured only when a new frame begins
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        w_d     = w_q;
        h_d     = h_q;
        if (state_q == ST_IDLE) begin
            hcnt_d  = '0;
            vcnt_d  = '0;
            state_d = enable_i ? ST_VS : ST_IDLE;
        end else begin
            hcnt_d  = line_end ? '0 : hcnt_q + HCNT_W'(1);
            vcnt_d  = state_end ? '0 : line_end ? vcnt_q + VCNT_W'(1) : vcnt_q;
            state_d = state_end ? state_nxt : state_q;
        end
        if (state_d == ST_VS && state_q != ST_VS) begin
            w_d = resol_i == P_RESOL_XGA ? VCNT_W'(P_XGA_W) : resol_i == P_RESOL_SXGA ? VCNT_W'(P_SXGA_W) : VCNT_W'(P_VGA_W);
            h_d = resol_i == P_RESOL_XGA ? VCNT_W'(P_XGA_H) : resol_i == P_RESOL_SXGA ? VCNT_W'(P_SXGA_H) : VCNT_W'(P_VGA_H);
        end
    end

    // State, counter and geometry registers
    always_ff @(posedge PCLK) begin
        if (!PRST_N) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            w_q     <= w_d;
            h_q     <= h_d;
        end
    end

endmodule

// File: rtl/cam_encoder.sv
// cam_encoder: pops RGB888 pixel pairs from a FWFT FIFO and emits an RGB565 camera byte stream
module cam_encoder
    import cam_encoder_pkg::*;
#(
    parameter int P_HBLANK      = 144,
    parameter int P_VSYNC_LINES = 3,
    parameter int P_VBP_LINES   = 17,
    parameter int P_VFP_LINES   = 10,
    parameter int P_VGA_W       = VGA_W,
    parameter int P_VGA_H       = VGA_H,
    parameter int P_XGA_W       = XGA_W,
    parameter int P_XGA_H       = XGA_H,
    parameter int P_SXGA_W      = SXGA_W,
    parameter int P_SXGA_H      = SXGA_H
) (
    input logic          PCLK,
    input logic          PRST_N,
    cam_encoder_if.slave bus
);
    logic        href_raw, vsync_raw, frameend_raw, fetch;
    logic [1:0]  phase;
    logic [47:0] word, hold_q, hold_d;
    logic [23:0] pix;
    logic [15:0] pix565;
    logic [7:0]  data_q, data_d;
    logic        href_q, vsync_q, frameend_q, underflow_q, underflow_d;
    logic        unused_pix;

    cam_timing_gen #(
        .P_HBLANK(P_HBLANK), .P_VSYNC_LINES(P_VSYNC_LINES), .P_VBP_LINES(P_VBP_LINES), .P_VFP_LINES(P_VFP_LINES),
        .P_VGA_W(P_VGA_W), .P_VGA_H(P_VGA_H), .P_XGA_W(P_XGA_W), .P_XGA_H(P_XGA_H),
        .P_SXGA_W(P_SXGA_W), .P_SXGA_H(P_SXGA_H)
    ) u_timing (
        .PCLK(PCLK),
        .PRST_N(PRST_N),
        .enable_i(bus.ENABLE),
        .resol_i(bus.RESOL),
        .href_o(href_raw),
        .vsync_o(vsync_raw),
        .frameend_o(frameend_raw),
        .phase_o(phase)
    );

    // Fetch on the first byte of each word; an empty FIFO substitutes an all-zero word
    always_comb begin
        fetch       = href_raw && phase == 2'd0;
        word        = bus.FIFOEMPTY ? '0 : bus.FIFOOUT;
        hold_d      = fetch ? word : hold_q;
        underflow_d = underflow_q || (fetch && bus.FIFOEMPTY);
        pix         = phase[1] ? hold_q[47:24] : phase[0] ? hold_q[23:0] : word[23:0];
        pix565      = rgb565(pix[23:19], pix[15:10], pix[7:3]);
        data_d      = !href_raw ? 8'h00 : phase[0] ? pix565[7:0] : pix565[15:8];
    end

    assign unused_pix    = ^{pix[18:16], pix[9:8], pix[2:0]};
    assign bus.FIFORD    = PRST_N && fetch && !bus.FIFOEMPTY;
    assign bus.HREF      = href_q;
    assign bus.VSYNC     = vsync_q;
    assign bus.CAMDATA   = data_q;
    assign bus.FRAMEEND  = frameend_q;
    assign bus.UNDERFLOW = underflow_q;

    // Output registers delay sync and data together so HREF and CAMDATA stay aligned
    always_ff @(posedge PCLK) begin
        if (!PRST_N) begin
            hold_q      <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            frameend_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            hold_q      <= hold_d;
            href_q      <= href_raw;
            vsync_q     <= vsync_raw;
            frameend_q  <= frameend_raw;
            underflow_q <= underflow_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_cam_encoder.sv
// tb_cam_encoder: frame-level reference model checks of the camera encoder with scaled-down geometry
module tb_cam_encoder;
    localparam int HB = 6, NVS = 2, NVBP = 2, NVFP = 2;
    localparam int VW = 16, VH = 4, XW = 20, XH = 5, SW = 24, SH = 6;

    logic pclk = 1'b0;
    logic prst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    logic [47:0] fifo[$];
    logic [7:0] act_bytes[$];
    logic rd_s;
    logic uf_model;
    int rd_cnt;

    cam_encoder_if bus();

    cam_encoder #(
        .P_HBLANK(HB), .P_VSYNC_LINES(NVS), .P_VBP_LINES(NVBP), .P_VFP_LINES(NVFP),
        .P_VGA_W(VW), .P_VGA_H(VH), .P_XGA_W(XW), .P_XGA_H(XH), .P_SXGA_W(SW), .P_SXGA_H(SH)
    ) dut (
        .PCLK(pclk),
        .PRST_N(prst_n),
        .bus(bus.slave)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] obs();
        return {4'h0, bus.HREF, bus.VSYNC, bus.FRAMEEND, bus.UNDERFLOW, bus.CAMDATA};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [15:0] o, input logic [15:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, e);
        end
    endtask

    task automatic drive_fifo();
        bus.FIFOEMPTY = fifo.size() == 0;
        bus.FIFOOUT = fifo.size() == 0 ? 48'hDEAD_BEEF_CAFE : fifo[0];
    endtask

    task automatic step();
        #1;
        rd_s = bus.FIFORD;
        @(posedge pclk);
        #1;
        if (rd_s === 1'b1) begin
            rd_cnt++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        drive_fifo();
        #1;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int n_words,
                             input int en_k, input int resol_k, input logic [1:0] resol_nxt, input int abort_k);
        int L, T, line, col, a, n;
        logic [47:0] src[$];
        logic [47:0] wd;
        logic [23:0] px;
        logic [7:0] b;
        logic act;
        L = 2 * w + HB;
        T = (NVS + NVBP + h + NVFP) * L;
        rd_cnt = 0;
        act_bytes.delete();
        for (int i = 0; i < n_words; i++) begin
            wd = i == 0 ? 48'h00FF00_FF0000 : i == 1 ? {48{1'b1}} : {16'($urandom), $urandom};
            src.push_back(wd);
            fifo.push_back(wd);
        end
        drive_fifo();
        for (int k = 0; k < T; k++) begin
            if (k == en_k) bus.ENABLE = 1'b0;
            if (k == resol_k) bus.RESOL = resol_nxt;
            if (k == abort_k) begin
                prst_n = 1'b0;
                step();
                chk({tag, "_abort_out"}, k, obs(), 16'h0000);
                chk({tag, "_abort_rd"}, k, {15'h0, bus.FIFORD}, 16'h0000);
                return;
            end
            step();
            line = k / L;
            col = k % L;
            a = line - NVS - NVBP;
            act = a >= 0 && a < h && col < 2 * w;
            n = a * (w / 2) + col / 4;
            wd = (act && n < n_words) ? src[n] : 48'h0;
            if (act && n >= n_words) uf_model = 1'b1;
            px = col % 4 < 2 ? wd[23:0] : wd[47:24];
            b = !act ? 8'h00 : col % 2 == 0 ? {px[23:19], px[15:13]} : {px[12:10], px[7:3]};
            chk(tag, k, obs(), {4'h0, act, line < NVS, k == T - 1, uf_model, b});
            if (act) act_bytes.push_back(bus.CAMDATA);
        end
        chk({tag, "_reads"}, 0, 16'(rd_cnt), 16'(n_words < w * h / 2 ? n_words : w * h / 2));
    endtask

    initial begin
        logic [7:0] exp_b[8];
        exp_b = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        bus.ENABLE = 1'b0;
        bus.RESOL = 2'b00;
        uf_model = 1'b0;
        rd_cnt = 0;
        drive_fifo();
        prst_n = 1'b0;
        repeat (3) step();
        chk("reset_out", 0, obs(), 16'h0000);
        chk("reset_rd", 0, {15'h0, bus.FIFORD}, 16'h0000);
        prst_n = 1'b1;
        step();
        chk("idle_out", 0, obs(), 16'h0000);
        bus.ENABLE = 1'b1;
        step();
        chk("start_out", 0, obs(), 16'h0000);
        run_frame("vga", VW, VH, VW * VH / 2, -1, (NVS + NVBP + 2) * (2 * VW + HB), 2'b10, -1);
        for (int i = 0; i < 8; i++)
            chk("byte_map", i, act_bytes.size() > i ? {8'h00, act_bytes[i]} : 16'hBAD0, {8'h00, exp_b[i]});
        run_frame("sxga_uf", SW, SH, 10, -1, 5, 2'b11, -1);
        run_frame("resol11", VW, VH, VW * VH / 2, (NVS + NVBP + VH + NVFP) * (2 * VW + HB) / 2, -1, 2'b11, -1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_after_drop", i, obs(), 16'h0100);
        end
        prst_n = 1'b0;
        step();
        chk("reset_clears_uf", 0, obs(), 16'h0000);
        uf_model = 1'b0;
        prst_n = 1'b1;
        bus.RESOL = 2'b01;
        bus.ENABLE = 1'b1;
        step();
        chk("start_xga", 0, obs(), 16'h0000);
        run_frame("xga_rst", XW, XH, XW * XH / 2, -1, -1, 2'b01, (NVS + NVBP + 2) * (2 * XW + HB) + 3);
        prst_n = 1'b1;
        bus.ENABLE = 1'b0;
        fifo.delete();
        drive_fifo();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_post_reset", i, obs(), 16'h0000);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
